e_operand_unit: RTL and testbench
=================================

Name: e_operand_unit

Overview:
- Parametrised E-stage operand unit for the pipelined MIPS core.
- Holds the D/E pipeline register for both register operands, the immediate and the operand-2 mode.
- Resolves M- and W-stage forwarding onto the registered operands and produces the final ALU operands and the store-data operand.
- Supports stall (hold) and flush (bubble); during a stall it refreshes the held operands from forwarding so in-flight results are not lost.

Parameters:
- DATA_W, 32, operand/result width; must be > IMM_W.
- IMM_W, 16, immediate field width.
- REG_AW, 5, register-number width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- D_valid  in  1  D stage holds a real instruction.
- D_rdata1  in  DATA_W  GRF read data, rs.
- D_rdata2  in  DATA_W  GRF read data, rt.
- D_rs  in  REG_AW  rs number.
- D_rt  in  REG_AW  rt number.
- D_imm  in  IMM_W  immediate field.
- D_s_data2  in  2  operand-2 mode: 00 RDATA2, 01 sign-ext, 10 zero-ext, 11 LUI.
- stall  in  1  hold the E register.
- flush  in  1  load a bubble into E.
- M_we  in  1  M-stage result will be written to the GRF.
- M_waddr  in  REG_AW  M-stage destination register.
- M_wdata  in  DATA_W  M-stage forward value.
- W_we  in  1  W-stage write enable.
- W_waddr  in  REG_AW  W-stage destination register.
- W_wdata  in  DATA_W  W-stage forward value.
- E_valid  out  1  E stage holds a real instruction.
- E_data1  out  DATA_W  ALU operand 1 (forwarded rs).
- E_data2  out  DATA_W  ALU operand 2 (selected per mode).
- E_store_data  out  DATA_W  forwarded rt, for SW/M stage.
- E_fwd_sel1  out  2  debug: 00 reg, 01 M, 10 W.
- E_fwd_sel2  out  2  debug: 00 reg, 01 M, 10 W.

Behaviour:
- Reset (reset=0, asynchronous): all E registers clear to 0; E_valid=0; all outputs 0.
- Register update on posedge clk, priority flush > stall > load.
  - flush=1: E_valid=0 and every field=0, regardless of stall.
  - stall=1, flush=0: E_rs, E_rt, E_imm, E_mode and E_valid hold. E_rdata1 loads fwd1 and E_rdata2 loads fwd2 (the refresh).
  - Otherwise: every field loads from the corresponding D_* input.
- Forwarding is combinational from registered E_rs/E_rt.
  - fwd1: M_wdata if M_we && M_waddr==E_rs && E_rs!=0; else W_wdata if W_we && W_waddr==E_rs && E_rs!=0; else E_rdata1.
  - fwd2: same rule using E_rt.
  - M has priority over W when both match.
  - Register 0 is never forwarded; its value is always E_rdataX as registered.
- Outputs:
  - E_data1 = fwd1.
  - E_store_data = fwd2.
- E_data2 by E_mode:
  - 00 → fwd2.
  - 01 → IMM_W sign-extended to DATA_W.
  - 10 → zero-extended.
  - 11 → {E_imm, (DATA_W-IMM_W) zeros}.
- Latency: one cycle from D inputs to E outputs; zero cycles from M/W forward inputs to E outputs.
- E_fwd_sel1/E_fwd_sel2 reflect the path chosen in the same cycle.
- E_valid has no effect on the datapath; a bubble outputs whatever was loaded (zeros after flush).
- Reset mid-stall: state is lost and E_valid=0; no refresh happens while reset is low.

Decomposition:
- Shared package/header holds:
  - operand-2 mode constants (RDATA2=2'b00, EXT=2'b01, ZERO_EXT=2'b10, LUI=2'b11);
  - forward-select encodings (FWD_REG, FWD_M, FWD_W).
- One sub-module: e_fwd_sel (a combinational, parametrised priority forward selector). It is instantiated twice, for rs and rt, and returns data plus select code.

Test Plan:
- Reset: reset low mid-run → all outputs 0 and E_valid=0 immediately, without waiting for clk; after release, the first load captures D_*.
- Modes with D_imm=16'h8001, D_rdata2=32'h0000_1234:
  - 00 → E_data2=32'h0000_1234;
  - 01 → 32'hFFFF_8001;
  - 10 → 32'h0000_8001;
  - 11 → 32'h8001_0000.
- Forwarding priority: E_rs=5, M_we=1/M_waddr=5/M_wdata=32'hAAAA_AAAA, W_we=1/W_waddr=5/W_wdata=32'h5555_5555 → E_data1=32'hAAAA_AAAA, sel1=01. Then M_we=0 → E_data1=32'h5555_5555, sel1=10.
- Zero register: E_rt=0, M_we=1, M_waddr=0, M_wdata=32'hDEAD_BEEF → E_store_data=E_rdata2, sel2=00.
- Stall refresh: E_rt=7, stall=1, W forwards 32'h0000_00FF to r7 for one cycle, then W_we=0 while stall persists → E_store_data stays 32'h0000_00FF. E_imm and mode are unchanged.
- Flush vs stall: stall=1 and flush=1 on the same edge → E_valid=0 and all outputs 0. Next edge with both low → captures D_*.

Source files
------------

// File: rtl/e_operand_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e_operand_unit_pkg
// Brief    : Shared encodings for the E-stage operand unit: operand-2 modes
//            and forward-path select codes.
// Revision : 1.0
// ============================================================================
package e_operand_unit_pkg;

    localparam logic [1:0] C_MODE_RDATA2   = 2'b00;
    localparam logic [1:0] C_MODE_EXT      = 2'b01;
    localparam logic [1:0] C_MODE_ZERO_EXT = 2'b10;
    localparam logic [1:0] C_MODE_LUI      = 2'b11;

    localparam logic [1:0] C_FWD_REG = 2'b00;
    localparam logic [1:0] C_FWD_M   = 2'b01;
    localparam logic [1:0] C_FWD_W   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/e_operand_unit_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : e_fwd_sel
// Brief    : Combinational M-over-W priority forward selector for one operand.
// Revision : 1.0
// ============================================================================
module e_fwd_sel
    import e_operand_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] e_reg,
    input  logic [DATA_W-1:0] e_rdata,
    input  logic              M_we,
    input  logic [REG_AW-1:0] M_waddr,
    input  logic [DATA_W-1:0] M_wdata,
    input  logic              W_we,
    input  logic [REG_AW-1:0] W_waddr,
    input  logic [DATA_W-1:0] W_wdata,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        fwd_sel
);

    logic w_nonzero;
    logic w_hit_m;
    logic w_hit_w;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    assign w_nonzero = (e_reg != '0);
    assign w_hit_m   = M_we && (M_waddr == e_reg) && w_nonzero;
    assign w_hit_w   = W_we && (W_waddr == e_reg) && w_nonzero;

    always_comb begin
        fwd_data = e_rdata;
        fwd_sel  = C_FWD_REG;
        if (w_hit_m) begin
            fwd_data = M_wdata;
            fwd_sel  = C_FWD_M;
        end else if (w_hit_w) begin
            fwd_data = W_wdata;
            fwd_sel  = C_FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/e_operand_unit.sv
`default_nettype none
// ============================================================================
// Module   : e_operand_unit
// Brief    : D/E pipeline register with M/W forwarding and ALU operand muxing.
// Revision : 1.0
// ============================================================================
module e_operand_unit
    import e_operand_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              D_valid,
    input  logic [DATA_W-1:0] D_rdata1,
    input  logic [DATA_W-1:0] D_rdata2,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic [IMM_W-1:0]  D_imm,
    input  logic [1:0]        D_s_data2,
    input  logic              stall,
    input  logic              flush,
    input  logic              M_we,
    input  logic [REG_AW-1:0] M_waddr,
    input  logic [DATA_W-1:0] M_wdata,
    input  logic              W_we,
    input  logic [REG_AW-1:0] W_waddr,
    input  logic [DATA_W-1:0] W_wdata,
    output logic              E_valid,
    output logic [DATA_W-1:0] E_data1,
    output logic [DATA_W-1:0] E_data2,
    output logic [DATA_W-1:0] E_store_data,
    output logic [1:0]        E_fwd_sel1,
    output logic [1:0]        E_fwd_sel2
);

    localparam int C_PAD_W = DATA_W - IMM_W;

    logic              valid_q,  valid_d;
    logic [REG_AW-1:0] rs_q,     rs_d;
    logic [REG_AW-1:0] rt_q,     rt_d;
    logic [IMM_W-1:0]  imm_q,    imm_d;
    logic [1:0]        mode_q,   mode_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;

    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;
    logic [1:0]        w_sel1;
    logic [1:0]        w_sel2;

    e_fwd_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .e_reg    (rs_q),
        .e_rdata  (rdata1_q),
        .M_we     (M_we),
        .M_waddr  (M_waddr),
        .M_wdata  (M_wdata),
        .W_we     (W_we),
        .W_waddr  (W_waddr),
        .W_wdata  (W_wdata),
        .fwd_data (w_fwd1),
        .fwd_sel  (w_sel1)
    );

    e_fwd_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .e_reg    (rt_q),
        .e_rdata  (rdata2_q),
        .M_we     (M_we),
        .M_waddr  (M_waddr),
        .M_wdata  (M_wdata),
        .W_we     (W_we),
        .W_waddr  (W_waddr),
        .W_wdata  (W_wdata),
        .fwd_data (w_fwd2),
        .fwd_sel  (w_sel2)
    );

    always_comb begin
        valid_d  = D_valid;
        rs_d     = D_rs;
        rt_d     = D_rt;
        imm_d    = D_imm;
        mode_d   = D_s_data2;
        rdata1_d = D_rdata1;
        rdata2_d = D_rdata2;
        if (flush) begin
            valid_d  = 1'b0;
            rs_d     = '0;
            rt_d     = '0;
            imm_d    = '0;
            mode_d   = '0;
            rdata1_d = '0;
            rdata2_d = '0;
        end else if (stall) begin
            // Held operands absorb in-flight results so they survive the stall.
            valid_d  = valid_q;
            rs_d     = rs_q;
            rt_d     = rt_q;
            imm_d    = imm_q;
            mode_d   = mode_q;
            rdata1_d = w_fwd1;
            rdata2_d = w_fwd2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            mode_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            valid_q  <= valid_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
            mode_q   <= mode_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    always_comb begin
        case (mode_q)
            C_MODE_EXT:      E_data2 = {{C_PAD_W{imm_q[IMM_W-1]}}, imm_q};
            C_MODE_ZERO_EXT: E_data2 = {{C_PAD_W{1'b0}}, imm_q};
            C_MODE_LUI:      E_data2 = {imm_q, {C_PAD_W{1'b0}}};
            default:         E_data2 = w_fwd2;
        endcase
    end

    assign E_valid      = valid_q;
    assign E_data1      = w_fwd1;
    assign E_store_data = w_fwd2;
    assign E_fwd_sel1   = w_sel1;
    assign E_fwd_sel2   = w_sel2;

endmodule
`default_nettype wire

// File: tb/tb_e_operand_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_e_operand_unit
// Brief    : Directed self-checking bench for e_operand_unit.
// Revision : 1.0
// ============================================================================
module tb_e_operand_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_valid;
    logic [31:0] D_rdata1, D_rdata2;
    logic [4:0]  D_rs, D_rt;
    logic [15:0] D_imm;
    logic [1:0]  D_s_data2;
    logic        stall, flush;
    logic        M_we, W_we;
    logic [4:0]  M_waddr, W_waddr;
    logic [31:0] M_wdata, W_wdata;
    logic        E_valid;
    logic [31:0] E_data1, E_data2, E_store_data;
    logic [1:0]  E_fwd_sel1, E_fwd_sel2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    e_operand_unit #(.DATA_W(32), .IMM_W(16), .REG_AW(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .D_valid      (D_valid),
        .D_rdata1     (D_rdata1),
        .D_rdata2     (D_rdata2),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .D_imm        (D_imm),
        .D_s_data2    (D_s_data2),
        .stall        (stall),
        .flush        (flush),
        .M_we         (M_we),
        .M_waddr      (M_waddr),
        .M_wdata      (M_wdata),
        .W_we         (W_we),
        .W_waddr      (W_waddr),
        .W_wdata      (W_wdata),
        .E_valid      (E_valid),
        .E_data1      (E_data1),
        .E_data2      (E_data2),
        .E_store_data (E_store_data),
        .E_fwd_sel1   (E_fwd_sel1),
        .E_fwd_sel2   (E_fwd_sel2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, E_valid}, 32'd0);
        chk({tag, "_d1"},    E_data1, 32'd0);
        chk({tag, "_d2"},    E_data2, 32'd0);
        chk({tag, "_st"},    E_store_data, 32'd0);
        chk({tag, "_sel"},   {28'd0, E_fwd_sel1, E_fwd_sel2}, 32'd0);
    endtask

    task automatic load_d(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [15:0] imm, input logic [1:0] mode);
        D_valid = 1'b1; D_rs = rs; D_rt = rt;
        D_rdata1 = r1; D_rdata2 = r2; D_imm = imm; D_s_data2 = mode;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        M_we = 1'b0; M_waddr = '0; M_wdata = '0;
        W_we = 1'b0; W_waddr = '0; W_wdata = '0;
        load_d(5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 2'b00);
        D_valid = 1'b0;
        step(); step();
        all_zero("reset");

        // Operand-2 modes
        reset = 1'b1;
        load_d(5'd3, 5'd4, 32'h1111_1111, 32'h0000_1234, 16'h8001, 2'b00);
        step();
        chk("load_valid", {31'd0, E_valid}, 32'd1);
        chk("load_d1", E_data1, 32'h1111_1111);
        chk("mode00", E_data2, 32'h0000_1234);
        D_s_data2 = 2'b01; step();
        chk("mode01", E_data2, 32'hFFFF_8001);
        D_s_data2 = 2'b10; step();
        chk("mode10", E_data2, 32'h0000_8001);
        D_s_data2 = 2'b11; step();
        chk("mode11", E_data2, 32'h8001_0000);
        chk("mode11_st", E_store_data, 32'h0000_1234);

        // Forwarding priority on rs
        load_d(5'd5, 5'd4, 32'h0101_0101, 32'h0000_1234, 16'h0000, 2'b00);
        step();
        M_we = 1'b1; M_waddr = 5'd5; M_wdata = 32'hAAAA_AAAA;
        W_we = 1'b1; W_waddr = 5'd5; W_wdata = 32'h5555_5555;
        #1;
        chk("fwd_m_d1", E_data1, 32'hAAAA_AAAA);
        chk("fwd_m_sel1", {30'd0, E_fwd_sel1}, 32'd1);
        chk("fwd_m_st", E_store_data, 32'h0000_1234);
        M_we = 1'b0; #1;
        chk("fwd_w_d1", E_data1, 32'h5555_5555);
        chk("fwd_w_sel1", {30'd0, E_fwd_sel1}, 32'd2);
        W_we = 1'b0; #1;
        chk("fwd_none_d1", E_data1, 32'h0101_0101);
        chk("fwd_none_sel1", {30'd0, E_fwd_sel1}, 32'd0);

        // Register 0 never forwarded
        load_d(5'd3, 5'd0, 32'h0, 32'h0000_0042, 16'h0000, 2'b00);
        step();
        M_we = 1'b1; M_waddr = 5'd0; M_wdata = 32'hDEAD_BEEF;
        #1;
        chk("r0_st", E_store_data, 32'h0000_0042);
        chk("r0_d2", E_data2, 32'h0000_0042);
        chk("r0_sel2", {30'd0, E_fwd_sel2}, 32'd0);
        M_we = 1'b0;

        // Stall refresh of rt from W
        load_d(5'd3, 5'd7, 32'h0, 32'h0000_0011, 16'h00F0, 2'b10);
        step();
        stall = 1'b1;
        W_we = 1'b1; W_waddr = 5'd7; W_wdata = 32'h0000_00FF;
        load_d(5'd9, 5'd9, 32'h9999_9999, 32'h0000_0099, 16'h1234, 2'b11);
        #1;
        chk("stall_fwd_st", E_store_data, 32'h0000_00FF);
        chk("stall_fwd_sel2", {30'd0, E_fwd_sel2}, 32'd2);
        step();
        W_we = 1'b0; #1;
        chk("stall_held_st", E_store_data, 32'h0000_00FF);
        chk("stall_held_sel2", {30'd0, E_fwd_sel2}, 32'd0);
        chk("stall_held_d2", E_data2, 32'h0000_00F0);
        step();
        chk("stall2_st", E_store_data, 32'h0000_00FF);
        chk("stall2_valid", {31'd0, E_valid}, 32'd1);

        // Asynchronous reset in the middle of a stall
        #2 reset = 1'b0;
        #1;
        all_zero("async_rst");
        @(negedge clk);
        reset = 1'b1; stall = 1'b0;
        load_d(5'd3, 5'd4, 32'h2222_2222, 32'h3333_3333, 16'h0001, 2'b01);
        step();
        chk("post_rst_d1", E_data1, 32'h2222_2222);
        chk("post_rst_d2", E_data2, 32'h0000_0001);
        chk("post_rst_st", E_store_data, 32'h3333_3333);
        chk("post_rst_valid", {31'd0, E_valid}, 32'd1);

        // Flush beats stall
        stall = 1'b1; flush = 1'b1;
        step();
        all_zero("flush");
        stall = 1'b0; flush = 1'b0;
        load_d(5'd6, 5'd8, 32'h4444_4444, 32'h5678_0000, 16'hABCD, 2'b11);
        step();
        chk("post_flush_d1", E_data1, 32'h4444_4444);
        chk("post_flush_d2", E_data2, 32'hABCD_0000);
        chk("post_flush_st", E_store_data, 32'h5678_0000);
        chk("post_flush_valid", {31'd0, E_valid}, 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
